decrypt_function_3: RTL

DECRYPT_FUNCTION_3 -- requirements
Module: decrypt_function_3

---
 rtl/decrypt_function_3_if.sv | 34 +++
 rtl/decrypt_function_3.sv | 122 ++++++++++++
 2 files changed

// File: rtl/decrypt_function_3_if.sv
// Handshake bundle for decrypt_function_3: frame-in stream and result-out stream.
// master = producer of frames / consumer of results, slave = the decrypt block.
interface decrypt_function_3_if;
    logic [77:0] in_enc;
    logic        in_valid;
    logic        in_ready;
    logic [59:0] out_data;
    logic [5:0]  out_rand6;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_enc,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_rand6,
        input  out_err,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_enc,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_rand6,
        output out_err,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/decrypt_function_3.sv
// Function-3 frame decryptor: two-stage valid/ready pipeline.
// S1 holds the captured frame with its pre-built key, S2 is the output register
// holding x - key, the range-check flag and the pass-through rand_6.
// A saturating counter tracks how many flagged results the consumer accepted.
module decrypt_function_3 #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    decrypt_function_3_if.slave bus,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned X_W    = 61;
    localparam int unsigned KEY_W  = 60;
    localparam int unsigned R11_W  = 11;
    localparam int unsigned R6_W   = 6;
    localparam int unsigned DATA_W = 60;

    // Key layout, LSB first: ~r, r, r, ~r, r, then r[4:0] to fill 60 bits.
    function automatic logic [KEY_W-1:0] build_key(input logic [R11_W-1:0] r);
        return {r[4:0], r, ~r, r, r, ~r};
    endfunction

    // Frame fields
    logic [X_W-1:0]   in_x;
    logic [R11_W-1:0] in_r11;
    logic [R6_W-1:0]  in_r6;

    assign in_x   = bus.in_enc[77:17];
    assign in_r11 = bus.in_enc[16:6];
    assign in_r6  = bus.in_enc[5:0];

    // Stage 1 state
    logic             s1_valid;
    logic [X_W-1:0]   s1_x;
    logic [KEY_W-1:0] s1_b;
    logic [R6_W-1:0]  s1_r6;

    // Stage 2 (output) state
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [R6_W-1:0]   out_rand6_q;
    logic              out_err_q;
    logic [CNT_W-1:0]  err_cnt_q;

    // Handshake control
    logic in_ready;
    logic accept;
    logic advance;
    logic out_fire;

    // S1 may hand over when S2 is empty or is being drained this cycle.
    assign advance  = s1_valid && (!out_valid_q || bus.out_ready);
    // in_ready is a function of state and out_ready only, never of in_valid.
    assign in_ready = !s1_valid || advance;
    assign accept   = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;

    // Subtraction with one extra bit so the borrow is visible as the top bit.
    logic [X_W:0]   diff_full;
    logic [X_W-1:0] diff;
    logic           borrow;
    logic           err_next;

    assign diff_full = {1'b0, s1_x} - {2'b00, s1_b};
    assign borrow    = diff_full[X_W];
    assign diff      = diff_full[X_W-1:0];
    // Valid plaintext must fit in 60 bits and must not come from an underflow.
    assign err_next  = borrow | diff[X_W-1];

    // Stage 1: capture the accepted frame and precompute its key.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_b     <= '0;
            s1_r6    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_x     <= in_x;
            s1_b     <= build_key(in_r11);
            s1_r6    <= in_r6;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: load the result from S1, or empty once the consumer takes it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rand6_q <= '0;
            out_err_q   <= 1'b0;
        end else if (advance) begin
            out_valid_q <= 1'b1;
            out_data_q  <= diff[DATA_W-1:0];
            out_rand6_q <= s1_r6;
            out_err_q   <= err_next;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Error counter: count accepted flagged results, stick at all-ones.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            err_cnt_q <= '0;
        end else if (out_fire && out_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_rand6 = out_rand6_q;
    assign bus.out_err   = out_err_q;
    assign err_cnt       = err_cnt_q;

endmodule
